// File: rtl/result_share_arb_if.sv
// Handshake bundle between the hashing-core array, the shared result
// register and the host-side consumer.
interface result_share_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [DW:0]        out_q;
  logic               out_ack;
  logic [15:0]        result_cnt;
  logic               busy;

  modport master (
    output req, req_data, out_ack,
    input  gnt, out_q, result_cnt, busy
  );

  modport slave (
    input  req, req_data, out_ack,
    output gnt, out_q, result_cnt, busy
  );
endinterface

// File: rtl/result_share_arb.sv
// Round-robin arbiter that funnels NREQ core results into one {valid, data}
// holding register, with back-to-back pop/capture for one result per cycle.

module reg65 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Holding register with async clear and load enable
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module result_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 64
) (
  input  logic               clk,
  input  logic               clr_n,
  result_share_arb_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;
  logic [15:0]     r_cnt;
  logic [PW-1:0]   w_win;
  logic            w_any;
  logic            w_take;
  logic            w_en;
  logic            w_clr;
  logic [DW:0]     w_d;
  logic [DW:0]     w_q;
  logic [NREQ-1:0] w_gnt;

  // Round-robin search: first requester at or after the pointer, modulo NREQ
  always_comb begin
    int idx;
    idx   = 0;
    w_win = r_ptr;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && bus.req[idx]) begin
        w_any = 1'b1;
        w_win = PW'(idx);
      end else begin
        w_win = w_win;
      end
    end
  end

  // Next-state, capture strobe and register load control
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_take      = 1'b0;
    w_en        = 1'b0;
    w_d         = {1'b0, w_q[DW-1:0]};
    w_gnt       = {NREQ{1'b0}};
    case (r_state)
      ST_EMPTY: begin
        w_take = w_any & clr_n;
      end
      ST_FULL: begin
        if (bus.out_ack) begin
          // Pop clears only valid; data bits keep the last result
          w_en        = 1'b1;
          w_take      = w_any & clr_n;
          w_state_nxt = ST_EMPTY;
        end else begin
          w_en = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (w_take) begin
      w_en         = 1'b1;
      w_d          = {1'b1, bus.req_data[int'(w_win)*DW +: DW]};
      w_gnt[w_win] = 1'b1;
      w_state_nxt  = ST_FULL;
      w_ptr_nxt    = (int'(w_win) == NREQ - 1) ? {PW{1'b0}} : w_win + 1'b1;
    end else begin
      w_gnt = {NREQ{1'b0}};
    end
  end

  // State, round-robin pointer and capture counter
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_EMPTY;
      r_ptr   <= {PW{1'b0}};
      r_cnt   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_take) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign w_clr = ~clr_n;

  reg65 #(.W(DW + 1)) u_hold (
    .clk (clk),
    .clr (w_clr),
    .en  (w_en),
    .d   (w_d),
    .q   (w_q)
  );

  assign bus.gnt        = w_gnt;
  assign bus.out_q      = w_q;
  assign bus.busy       = w_q[DW];
  assign bus.result_cnt = r_cnt;
endmodule

// File: tb/tb_result_share_arb.sv
// Bench for result_share_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_result_share_arb;
  localparam int NREQ = 4;
  localparam int DW   = 64;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  result_share_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();
  result_share_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  // Model: the held result, rotating priority index, capture count
  logic            m_valid    = 1'b0;
  logic [DW-1:0]   m_data     = '0;
  int              m_ptr      = 0;
  logic [15:0]     m_cnt      = 16'h0000;
  logic [NREQ-1:0] m_last_gnt = '0;

  logic [DW-1:0] dv [NREQ];
  logic [NREQ-1:0] exp_g;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Which core wins this cycle, or -1 when no capture takes place
  function automatic int model_winner();
    if (!clr_n) return -1;
    if (m_valid && !bus.out_ack) return -1;
    for (int k = 0; k < NREQ; k++)
      if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ptr      <= 0;
      m_cnt      <= 16'h0000;
      m_last_gnt <= '0;
    end else if (model_winner() >= 0) begin
      m_valid    <= 1'b1;
      m_data     <= bus.req_data[model_winner()*DW +: DW];
      m_ptr      <= (model_winner() + 1) % NREQ;
      m_cnt      <= m_cnt + 16'd1;
      m_last_gnt <= onehot(model_winner());
    end else begin
      if (m_valid && bus.out_ack) m_valid <= 1'b0;
      m_last_gnt <= '0;
    end
  end

  always @(negedge clk) begin
    if (!clr_n) begin
      chk("rst_gnt", bus.gnt, '0);
      chk("rst_out_q", bus.out_q, '0);
      chk("rst_cnt", bus.result_cnt, '0);
      chk("rst_busy", bus.busy, '0);
    end else begin
      chk("gnt", bus.gnt, onehot(model_winner()));
      chk("out_q", bus.out_q, {m_valid, m_data});
      chk("result_cnt", bus.result_cnt, m_cnt);
      chk("busy", bus.busy, m_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    dv[0] = 64'hDEAD_BEEF_0000_0000;
    dv[1] = 64'h1111_2222_3333_4444;
    dv[2] = 64'h2222_CAFE_F00D_0002;
    dv[3] = 64'h3333_0123_4567_89AB;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = dv[i];
    bus.out_ack = 1'b0;
    bus.req     = 4'b1111;

    mid();
    mid();
    chk("reset_gnt", bus.gnt, '0);
    chk("reset_out_q", bus.out_q, '0);
    chk("reset_cnt", bus.result_cnt, '0);
    clr_n = 1'b1;
    #1 chk("first_gnt", bus.gnt, 4'b0001);
    tick();
    bus.req = 4'b0100;
    chk("first_capture", bus.out_q, {1'b1, dv[0]});

    // Full with ack low: nothing moves for five cycles
    repeat (5) begin
      mid();
      chk("hold_gnt", bus.gnt, '0);
      chk("hold_out_q", bus.out_q, {1'b1, dv[0]});
      chk("hold_busy", bus.busy, 1'b1);
      tick();
    end

    bus.out_ack = 1'b1;
    mid();
    chk("ptr_after_core0", bus.gnt, 4'b0100);
    tick();
    chk("cap_core2", bus.out_q, {1'b1, dv[2]});
    bus.req = 4'b1000;
    mid();
    chk("b2b_gnt", bus.gnt, 4'b1000);
    tick();
    chk("b2b_out_q", bus.out_q, {1'b1, dv[3]});
    bus.req = 4'b0000;
    mid();
    chk("drain_gnt", bus.gnt, '0);
    tick();
    chk("drain_out_q", bus.out_q, {1'b0, dv[3]});
    chk("drain_busy", bus.busy, 1'b0);
    chk("drain_cnt", bus.result_cnt, 16'd3);
    tick();
    chk("spurious_ack_out_q", bus.out_q, {1'b0, dv[3]});
    chk("spurious_ack_cnt", bus.result_cnt, 16'd3);

    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      mid();
      exp_g = '0;
      exp_g[k % NREQ] = 1'b1;
      chk("rr_gnt", bus.gnt, exp_g);
      chk("rr_cnt", bus.result_cnt, 16'(3 + k));
      tick();
    end
    chk("rr_cnt_end", bus.result_cnt, 16'd8);

    repeat (65535 - 8) tick();
    chk("cnt_max", bus.result_cnt, 16'hFFFF);
    tick();
    chk("cnt_wrap", bus.result_cnt, 16'h0000);
    bus.req     = 4'b0000;
    bus.out_ack = 1'b0;
    tick();

    // Asynchronous clear between edges while holding a result
    #2 clr_n = 1'b0;
    #1;
    chk("async_out_q", bus.out_q, '0);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_cnt", bus.result_cnt, '0);
    clr_n   = 1'b1;
    bus.req = 4'b0110;
    #1 chk("post_reset_lowest", bus.gnt, 4'b0010);

    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] || m_last_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.req[i] = 1'b1;
            bus.req_data[i*DW +: DW] = {$urandom, $urandom};
          end else begin
            bus.req[i] = 1'b0;
          end
        end
      end
      bus.out_ack = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 clr_n = 1'b0;
        #1 clr_n = 1'b1;
      end
    end

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
